// File: rtl/alu_mc.sv
// alu_mc: multi-cycle, handshaked ALU with a parametrised width.
//
// Single-cycle ops (ADD, XOR, OR, AND, SEQ, SLT, SUB, illegal) finish one
// cycle after accept. Shifts by b[SW-1:0] take one cycle per bit. The
// optional MUL does a shift-add over N cycles.
//
// Build option: define ALU_MUL_EN to enable opcode 10 (MUL). When it is not
// defined, opcode 10 is illegal and no multiplier datapath exists.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   in_valid   operation offered
//   in_ready   unit can accept (IDLE only)
//   opcode     operation select (4 bits)
//   a, b       operands, N bits (shift amount = b[SW-1:0])
//   out_valid  result/flags valid (DONE)
//   out_ready  consumer takes result
//   result     N-bit result
//   flags      {ill, neg, carry, zero}
module alu_mc #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   opcode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  localparam int SW = $clog2(N);
  localparam int CW = SW + 1;   // cnt must also hold N for MUL

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_XOR = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_SEQ = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SL  = 4'd6;
  localparam logic [3:0] OP_SR  = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SUB = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state, state_nx;
  logic [3:0]    op_q;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;
`ifdef ALU_MUL_EN
  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;
`endif

  logic          accept;
  logic          is_shift;
  logic          is_mul;
  logic [SW-1:0] shamt;
  logic          go_exec;
  logic          exec_last;
  logic [N:0]    sum;
  logic [N-1:0]  sc_res;
  logic          sc_carry;
  logic          sc_ill;
  logic [N-1:0]  step;

  assign accept    = in_valid && in_ready;
  assign shamt     = b[SW-1:0];
  assign is_shift  = (opcode == OP_SL) || (opcode == OP_SR) || (opcode == OP_SRL);
`ifdef ALU_MUL_EN
  assign is_mul    = (opcode == OP_MUL);
`else
  assign is_mul    = 1'b0;
`endif
  assign go_exec   = accept && ((is_shift && (shamt != '0)) || is_mul);
  assign exec_last = (state == EXEC) && (cnt <= CW'(1));
  assign sum       = {1'b0, a} + {1'b0, b};

  // Result of any op that completes straight from IDLE; a zero-length shift
  // simply passes a through.
  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ill   = 1'b0;
    case (opcode)
      OP_ADD: begin
        sc_res   = sum[N-1:0];
        sc_carry = sum[N];
      end
      OP_XOR: sc_res = a ^ b;
      OP_OR:  sc_res = a | b;
      OP_AND: sc_res = a & b;
      OP_SEQ: sc_res[0] = (a == b);
      OP_SLT: sc_res[0] = (a < b);
      OP_SL, OP_SR, OP_SRL: sc_res = a;
      OP_SUB: begin
        sc_res   = a - b;
        sc_carry = (a < b);
      end
`ifdef ALU_MUL_EN
      OP_MUL: sc_res = '0;
`else
      OP_MUL: sc_ill = 1'b1;
`endif
      default: sc_ill = 1'b1;
    endcase
  end

  // One EXEC step on the working register.
  always_comb begin
    step = acc;
    case (op_q)
      OP_SL:  step = {acc[N-2:0], 1'b0};
      OP_SR:  step = {acc[N-1], acc[N-1:1]};
      OP_SRL: step = {1'b0, acc[N-1:1]};
`ifdef ALU_MUL_EN
      OP_MUL: step = mplier[0] ? (acc + mcand) : acc;
`endif
      default: step = acc;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = go_exec ? EXEC : DONE;
      EXEC: if (exec_last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: operand capture, iteration, and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      flags  <= '0;
`ifdef ALU_MUL_EN
      mcand  <= '0;
      mplier <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= opcode;
          acc  <= a;
          cnt  <= {1'b0, shamt};
`ifdef ALU_MUL_EN
          if (is_mul) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= CW'(N);
          end
`endif
          if (!go_exec) begin
            result <= sc_res;
            flags  <= {sc_ill, sc_res[N-1], sc_carry, (sc_res == '0)};
          end
        end
        EXEC: begin
          acc <= step;
          cnt <= cnt - CW'(1);
`ifdef ALU_MUL_EN
          mcand  <= {mcand[N-2:0], 1'b0};
          mplier <= {1'b0, mplier[N-1:1]};
`endif
          if (exec_last) begin
            result <= step;
            flags  <= {1'b0, step[N-1], 1'b0, (step == '0)};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  alu_mc #(.N(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  typedef struct {
    logic [15:0] res;
    logic [3:0]  fl;
    int          cyc;
    int          tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   tag = 0;
  bit   seen = 0;
  bit   chk_idle = 0;
  int   first_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s #%0d: got=%h exp=%h", nm, t, act, exp);
    end
  endtask

  // Monitor: compares the presented result against the head of the scoreboard
  // every cycle out_valid is high, then pops on the handshake.
  always @(negedge clk) begin
    if (rst) begin
      seen     = 0;
      chk_idle = 0;
    end else begin
      if (chk_idle) begin
        check("idle_in_ready", -1, in_ready, 1);
        check("idle_out_valid", -1, out_valid, 0);
        chk_idle = 0;
      end
      if (out_valid) begin
        check("busy_in_ready", -1, in_ready, 0);
        if (!seen) begin
          seen      = 1;
          first_cyc = cyc;
        end
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got result=%h exp none", result);
        end else begin
          check("result", q[0].tag, result, q[0].res);
          check("flags", q[0].tag, flags, q[0].fl);
          if (out_ready) begin
            exp_t e;
            e = q.pop_front();
            check("latency", e.tag, first_cyc, e.cyc);
          end
        end
        if (out_ready) begin
          seen     = 0;
          chk_idle = 1;
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] er, input logic [3:0] ef, input int lat, input bit push);
    int n;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    opcode   = op;
    a        = av;
    b        = bv;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout #%0d: got in_ready=0 exp 1", tag);
    end else if (push) begin
      e.res = er;
      e.fl  = ef;
      e.cyc = cyc + lat;
      e.tag = tag;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode   = 4'($urandom);
    a        = 16'($urandom);
    b        = 16'($urandom);
    tag++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got pending=%0d exp 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    opcode    = '0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", -1, in_ready, 1);
    check("rst_out_valid", -1, out_valid, 0);
    check("rst_result", -1, result, 0);
    check("rst_flags", -1, flags, 0);
    rst = 1'b0;

    // flags = {ill, neg, carry, zero}
    issue(4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b0011, 1,  1); // ADD carry+zero
    issue(4'd1,  16'hF0F0, 16'h0FF0, 16'hFF00, 4'b0100, 1,  1); // XOR
    issue(4'd2,  16'h1200, 16'h0034, 16'h1234, 4'b0000, 1,  1); // OR
    issue(4'd3,  16'hFF00, 16'h0F0F, 16'h0F00, 4'b0000, 1,  1); // AND
    issue(4'd4,  16'h1234, 16'h1234, 16'h0001, 4'b0000, 1,  1); // SEQ
    issue(4'd5,  16'h8000, 16'h0001, 16'h0000, 4'b0001, 1,  1); // SLT unsigned
    issue(4'd9,  16'h0005, 16'h0003, 16'h0002, 4'b0000, 1,  1); // SUB no borrow
    issue(4'd6,  16'h0001, 16'h0004, 16'h0010, 4'b0000, 5,  1); // SL 4
    issue(4'd7,  16'h8000, 16'h0003, 16'hF000, 4'b0100, 4,  1); // SR 3 sign fill
    issue(4'd8,  16'h8000, 16'h0003, 16'h1000, 4'b0000, 4,  1); // SRL 3
    issue(4'd7,  16'h8001, 16'h0001, 16'hC000, 4'b0100, 2,  1); // SR 1
    issue(4'd7,  16'h4000, 16'h000F, 16'h0000, 4'b0001, 16, 1); // SR max amount
    issue(4'd6,  16'h1234, 16'h0010, 16'h1234, 4'b0000, 1,  1); // SL amount 0 (upper b ignored)
    issue(4'd15, 16'h1234, 16'h5678, 16'h0000, 4'b1001, 1,  1); // illegal
    issue(4'd12, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1001, 1,  1); // illegal
`ifdef ALU_MUL_EN
    issue(4'd10, 16'h00FF, 16'h0101, 16'hFFFF, 4'b0100, 17, 1); // MUL
    issue(4'd10, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 17, 1); // MUL
`else
    issue(4'd10, 16'h00FF, 16'h0101, 16'h0000, 4'b1001, 1,  1); // MUL disabled
`endif
    drain();

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    issue(4'd9, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Reset in the middle of a long operation
`ifdef ALU_MUL_EN
    issue(4'd10, 16'h00FF, 16'h0101, 16'h0000, 4'b0000, 17, 0);
`else
    issue(4'd7,  16'h4000, 16'h000F, 16'h0000, 4'b0000, 16, 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", -1, out_valid, 0);
    check("midrst_in_ready", -1, in_ready, 1);
    check("midrst_result", -1, result, 0);
    check("midrst_flags", -1, flags, 0);
    issue(4'd0, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 1, 1);
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
